// File: rtl/tcp_tx_slow_engine.sv
// TCP TX slow-path engine: per-flow scheduler command -> state read -> segment calc -> send descriptor -> seq write-back/pend clear.
// Optional TCP_TX_ZERO_WIN_PROBE_EN: 1-byte zero-window probe when peer window is exhausted.
module tcp_tx_slow_engine #(
    parameter int FLOWID_W         = 3,
    parameter int TX_PAYLOAD_PTR_W = 14,
    parameter int MSS              = 1460
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sched_cmd_val,
    input  logic [FLOWID_W-1:0]         sched_cmd_flowid,
    input  logic                        sched_cmd_ack,
    input  logic                        sched_cmd_rt,
    output logic                        sched_cmd_rdy,
    output logic                        state_rd_req_val,
    output logic [FLOWID_W-1:0]         state_rd_req_flowid,
    input  logic                        state_rd_resp_val,
    input  logic [31:0]                 state_rd_our_seq,
    input  logic [31:0]                 state_rd_acked_seq,
    input  logic [31:0]                 state_rd_their_ack,
    input  logic [15:0]                 state_rd_their_win,
    input  logic [15:0]                 state_rd_our_win,
    input  logic [TX_PAYLOAD_PTR_W:0]   state_rd_tx_tail,
    input  logic [31:0]                 state_rd_host_ip,
    input  logic [31:0]                 state_rd_dest_ip,
    input  logic [15:0]                 state_rd_host_port,
    input  logic [15:0]                 state_rd_dest_port,
    output logic                        pkt_val,
    input  logic                        pkt_rdy,
    output logic [31:0]                 pkt_src_ip,
    output logic [31:0]                 pkt_dst_ip,
    output logic [15:0]                 pkt_src_port,
    output logic [15:0]                 pkt_dst_port,
    output logic [31:0]                 pkt_seq,
    output logic [31:0]                 pkt_ack,
    output logic [7:0]                  pkt_flags,
    output logic [15:0]                 pkt_win,
    output logic [TX_PAYLOAD_PTR_W:0]   pkt_payload_addr,
    output logic [15:0]                 pkt_payload_len,
    output logic                        seq_wr_val,
    output logic [FLOWID_W-1:0]         seq_wr_flowid,
    output logic [31:0]                 seq_wr_data,
    output logic                        sched_clr_val,
    output logic [FLOWID_W-1:0]         sched_clr_flowid,
    output logic                        sched_clr_data,
    output logic                        sched_clr_ack,
    output logic                        sched_clr_rt
);
    localparam int P = TX_PAYLOAD_PTR_W;
    localparam logic [31:0] MSS_L = 32'(MSS);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, SEND, WB} state_t;
    state_t st, st_nxt;

    logic [FLOWID_W-1:0] cmd_flowid;
    logic                cmd_ack, cmd_rt;
    logic [31:0]         r_our_seq, r_acked, r_their_ack, r_host_ip, r_dest_ip;
    logic [15:0]         r_their_win, r_our_win, r_host_port, r_dest_port;
    logic [P:0]          r_tail;

    logic [31:0] seq_r, new_seq_r;
    logic [15:0] len_r;
    logic [7:0]  flags_r;
    logic        send_r, wr_r, clr_data_r;

    logic [P:0]  unsent;
    logic [31:0] unsent32, inflight, avail, win32, calc_len, seq_n, new_seq_n;
    logic        probe;

    function automatic logic [31:0] min2(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // Segment math: pointers wrap at 2^(P+1), sequence numbers at 2^32.
    always_comb begin
        unsent    = r_tail - r_our_seq[P:0];
        unsent32  = {{(31-P){1'b0}}, unsent};
        inflight  = r_our_seq - r_acked;
        win32     = {16'd0, r_their_win};
        avail     = (inflight >= win32) ? 32'd0 : (win32 - inflight);
        probe     = 1'b0;
        if (cmd_rt) begin
            calc_len = min2(min2(inflight, win32), MSS_L);
            seq_n    = r_acked;
        end else begin
            calc_len = min2(min2(unsent32, avail), MSS_L);
            seq_n    = r_our_seq;
`ifdef TCP_TX_ZERO_WIN_PROBE_EN
            if (avail == 32'd0 && unsent32 != 32'd0) begin
                calc_len = 32'd1;
                probe    = 1'b1;
            end
`endif
        end
        new_seq_n = (cmd_rt || probe) ? r_our_seq : (r_our_seq + calc_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (sched_cmd_val) st_nxt = RD_REQ;
            RD_REQ:  st_nxt = RD_WAIT;
            RD_WAIT: if (state_rd_resp_val) st_nxt = CALC;
            CALC:    st_nxt = SEND;
            SEND:    if (!send_r || pkt_rdy) st_nxt = WB;
            WB:      st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        sched_cmd_rdy    = (st == IDLE);
        state_rd_req_val = (st == RD_REQ);
        pkt_val          = (st == SEND) && send_r;
        seq_wr_val       = (st == WB) && wr_r;
        sched_clr_val    = (st == WB);
        sched_clr_ack    = (st == WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_flowid  <= '0;
            cmd_ack     <= 1'b0;
            cmd_rt      <= 1'b0;
            r_our_seq   <= '0;
            r_acked     <= '0;
            r_their_ack <= '0;
            r_their_win <= '0;
            r_our_win   <= '0;
            r_tail      <= '0;
            r_host_ip   <= '0;
            r_dest_ip   <= '0;
            r_host_port <= '0;
            r_dest_port <= '0;
            seq_r       <= '0;
            new_seq_r   <= '0;
            len_r       <= '0;
            flags_r     <= '0;
            send_r      <= 1'b0;
            wr_r        <= 1'b0;
            clr_data_r  <= 1'b0;
        end else begin
            if (st == IDLE && sched_cmd_val) begin
                cmd_flowid <= sched_cmd_flowid;
                cmd_ack    <= sched_cmd_ack;
                cmd_rt     <= sched_cmd_rt;
            end
            if (st == RD_WAIT && state_rd_resp_val) begin
                r_our_seq   <= state_rd_our_seq;
                r_acked     <= state_rd_acked_seq;
                r_their_ack <= state_rd_their_ack;
                r_their_win <= state_rd_their_win;
                r_our_win   <= state_rd_our_win;
                r_tail      <= state_rd_tx_tail;
                r_host_ip   <= state_rd_host_ip;
                r_dest_ip   <= state_rd_dest_ip;
                r_host_port <= state_rd_host_port;
                r_dest_port <= state_rd_dest_port;
            end
            if (st == CALC) begin
                seq_r      <= seq_n;
                new_seq_r  <= new_seq_n;
                len_r      <= calc_len[15:0];
                flags_r    <= (calc_len != 32'd0) ? 8'h18 : 8'h10;
                send_r     <= (calc_len != 32'd0) || cmd_ack || cmd_rt;
                wr_r       <= (calc_len != 32'd0) && !cmd_rt && !probe;
                clr_data_r <= (calc_len == unsent32) || (avail == 32'd0);
            end
        end
    end

    assign state_rd_req_flowid = cmd_flowid;
    assign pkt_src_ip          = r_host_ip;
    assign pkt_dst_ip          = r_dest_ip;
    assign pkt_src_port        = r_host_port;
    assign pkt_dst_port        = r_dest_port;
    assign pkt_seq             = seq_r;
    assign pkt_ack             = r_their_ack;
    assign pkt_flags           = flags_r;
    assign pkt_win             = r_our_win;
    assign pkt_payload_addr    = seq_r[P:0];
    assign pkt_payload_len     = len_r;
    assign seq_wr_flowid       = cmd_flowid;
    assign seq_wr_data         = new_seq_r;
    assign sched_clr_flowid    = cmd_flowid;
    assign sched_clr_data      = clr_data_r;
    assign sched_clr_rt        = cmd_rt;
endmodule

// File: tb/tb_tcp_tx_slow_engine.sv
// Scoreboard bench for tcp_tx_slow_engine: directed commands push expected descriptors and clears; a monitor pops and compares.
module tb_tcp_tx_slow_engine;
    localparam int FW = 3;
    localparam int P  = 14;

    logic clk = 1'b0, rst = 1'b1;
    logic sched_cmd_val = 1'b0, sched_cmd_ack = 1'b0, sched_cmd_rt = 1'b0;
    logic [FW-1:0] sched_cmd_flowid = '0;
    logic sched_cmd_rdy, state_rd_req_val, state_rd_resp_val = 1'b0;
    logic [FW-1:0] state_rd_req_flowid;
    logic [31:0] state_rd_our_seq = '0, state_rd_acked_seq = '0, state_rd_their_ack = '0;
    logic [15:0] state_rd_their_win = '0, state_rd_our_win = '0;
    logic [P:0]  state_rd_tx_tail = '0;
    logic [31:0] state_rd_host_ip = '0, state_rd_dest_ip = '0;
    logic [15:0] state_rd_host_port = '0, state_rd_dest_port = '0;
    logic pkt_val, pkt_rdy = 1'b1;
    logic [31:0] pkt_src_ip, pkt_dst_ip, pkt_seq, pkt_ack;
    logic [15:0] pkt_src_port, pkt_dst_port, pkt_win, pkt_payload_len;
    logic [7:0]  pkt_flags;
    logic [P:0]  pkt_payload_addr;
    logic seq_wr_val, sched_clr_val, sched_clr_data, sched_clr_ack, sched_clr_rt;
    logic [FW-1:0] seq_wr_flowid, sched_clr_flowid;
    logic [31:0] seq_wr_data;

    tcp_tx_slow_engine #(.FLOWID_W(FW), .TX_PAYLOAD_PTR_W(P), .MSS(1460)) dut (
        .clk(clk), .rst(rst),
        .sched_cmd_val(sched_cmd_val), .sched_cmd_flowid(sched_cmd_flowid),
        .sched_cmd_ack(sched_cmd_ack), .sched_cmd_rt(sched_cmd_rt), .sched_cmd_rdy(sched_cmd_rdy),
        .state_rd_req_val(state_rd_req_val), .state_rd_req_flowid(state_rd_req_flowid),
        .state_rd_resp_val(state_rd_resp_val), .state_rd_our_seq(state_rd_our_seq),
        .state_rd_acked_seq(state_rd_acked_seq), .state_rd_their_ack(state_rd_their_ack),
        .state_rd_their_win(state_rd_their_win), .state_rd_our_win(state_rd_our_win),
        .state_rd_tx_tail(state_rd_tx_tail), .state_rd_host_ip(state_rd_host_ip),
        .state_rd_dest_ip(state_rd_dest_ip), .state_rd_host_port(state_rd_host_port),
        .state_rd_dest_port(state_rd_dest_port),
        .pkt_val(pkt_val), .pkt_rdy(pkt_rdy), .pkt_src_ip(pkt_src_ip), .pkt_dst_ip(pkt_dst_ip),
        .pkt_src_port(pkt_src_port), .pkt_dst_port(pkt_dst_port), .pkt_seq(pkt_seq),
        .pkt_ack(pkt_ack), .pkt_flags(pkt_flags), .pkt_win(pkt_win),
        .pkt_payload_addr(pkt_payload_addr), .pkt_payload_len(pkt_payload_len),
        .seq_wr_val(seq_wr_val), .seq_wr_flowid(seq_wr_flowid), .seq_wr_data(seq_wr_data),
        .sched_clr_val(sched_clr_val), .sched_clr_flowid(sched_clr_flowid),
        .sched_clr_data(sched_clr_data), .sched_clr_ack(sched_clr_ack), .sched_clr_rt(sched_clr_rt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] src_ip, dst_ip;
        logic [15:0] src_port, dst_port;
        logic [31:0] seq, ack;
        logic [7:0]  flags;
        logic [15:0] win;
        logic [P:0]  addr;
        logic [15:0] len;
    } pkt_t;

    typedef struct packed {
        logic [FW-1:0] flowid;
        logic          wr;
        logic [31:0]   wr_data;
        logic          cdata, cack, crt;
    } clr_t;

    pkt_t pkt_q[$];
    clr_t clr_q[$];
    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-response model: resp_val one cycle after the request cycle.
    logic pend = 1'b0;
    always @(negedge clk) begin
        state_rd_resp_val = pend;
        pend = state_rd_req_val;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_val && pkt_rdy) begin
                pkt_t a, e;
                a = '{pkt_src_ip, pkt_dst_ip, pkt_src_port, pkt_dst_port, pkt_seq, pkt_ack,
                      pkt_flags, pkt_win, pkt_payload_addr, pkt_payload_len};
                tests++;
                if (pkt_q.size() == 0) begin
                    fails++;
                    $display("FAIL pkt_unexpected: got seq=%0h len=%0h flags=%0h expected no packet",
                             pkt_seq, pkt_payload_len, pkt_flags);
                end else begin
                    e = pkt_q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL pkt: got seq=%0h len=%0h flags=%0h ack=%0h addr=%0h expected seq=%0h len=%0h flags=%0h ack=%0h addr=%0h",
                                 a.seq, a.len, a.flags, a.ack, a.addr, e.seq, e.len, e.flags, e.ack, e.addr);
                    end
                end
            end
            if (sched_clr_val) begin
                clr_t e;
                tests++;
                if (clr_q.size() == 0) begin
                    fails++;
                    $display("FAIL clr_unexpected: got flow=%0h expected no clear", sched_clr_flowid);
                end else begin
                    e = clr_q.pop_front();
                    if (sched_clr_flowid !== e.flowid || seq_wr_val !== e.wr ||
                        (e.wr && (seq_wr_data !== e.wr_data || seq_wr_flowid !== e.flowid)) ||
                        sched_clr_data !== e.cdata || sched_clr_ack !== e.cack || sched_clr_rt !== e.crt) begin
                        fails++;
                        $display("FAIL wb: got flow=%0h wr=%0b data=%0h cd=%0b ca=%0b crt=%0b expected flow=%0h wr=%0b data=%0h cd=%0b ca=%0b crt=%0b",
                                 sched_clr_flowid, seq_wr_val, seq_wr_data, sched_clr_data, sched_clr_ack, sched_clr_rt,
                                 e.flowid, e.wr, e.wr_data, e.cdata, e.cack, e.crt);
                    end
                end
            end
            if (seq_wr_val && !sched_clr_val) begin
                tests++;
                fails++;
                $display("FAIL wr_without_clr: got seq_wr_val=1 expected 0 outside write-back");
            end
        end
    end

    task automatic set_state(input logic [31:0] os, input logic [31:0] ac, input logic [31:0] ta,
                             input logic [15:0] tw, input logic [P:0] tail);
        state_rd_our_seq   = os;
        state_rd_acked_seq = ac;
        state_rd_their_ack = ta;
        state_rd_their_win = tw;
        state_rd_tx_tail   = tail;
        state_rd_our_win   = 16'h2000;
        state_rd_host_ip   = 32'h0A00_0001;
        state_rd_dest_ip   = 32'h0A00_0002;
        state_rd_host_port = 16'h1234;
        state_rd_dest_port = 16'h0050;
    endtask

    task automatic push_pkt(input logic [31:0] seq, input logic [15:0] len, input logic [7:0] flags);
        logic [31:0] s;
        s = seq;
        pkt_q.push_back('{32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h0050, seq, state_rd_their_ack,
                          flags, 16'h2000, s[P:0], len});
    endtask

    task automatic push_clr(input logic [FW-1:0] f, input logic wr, input logic [31:0] d,
                            input logic cd, input logic ca, input logic crt);
        clr_q.push_back('{f, wr, d, cd, ca, crt});
    endtask

    task automatic send_cmd(input logic [FW-1:0] f, input logic ack, input logic rt);
        @(negedge clk);
        sched_cmd_val    = 1'b1;
        sched_cmd_flowid = f;
        sched_cmd_ack    = ack;
        sched_cmd_rt     = rt;
        @(negedge clk);
        sched_cmd_val    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!sched_cmd_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!sched_cmd_rdy) chk({name, "_timeout"}, 64'(sched_cmd_rdy), 64'd1);
    endtask

    task automatic wait_pkt(input string name);
        int n;
        n = 0;
        while (!pkt_val && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pkt_val"}, 64'(pkt_val), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(sched_cmd_rdy), 64'd1);
        chk("rst_vals", {60'd0, state_rd_req_val, pkt_val, seq_wr_val, sched_clr_val}, 64'd0);
        chk("rst_data", {pkt_seq, seq_wr_data}, 64'd0);
        rst = 1'b0;

        // Full MSS segment; also checks req pulse and 4-cycle accept->pkt_val latency.
        set_state(32'h100, 32'h100, 32'hA1, 16'hFFFF, 15'h0800);
        push_pkt(32'h100, 16'd1460, 8'h18);
        push_clr(3'd1, 1'b1, 32'h6B4, 1'b0, 1'b1, 1'b0);
        send_cmd(3'd1, 1'b0, 1'b0);
        chk("rd_req", {62'd0, state_rd_req_val, (state_rd_req_flowid == 3'd1)}, 64'd3);
        repeat (3) @(negedge clk);
        chk("latency4", 64'(pkt_val), 64'd1);
        wait_idle("t1");

        // Short tail: len = unsent, data pend cleared.
        set_state(32'h100, 32'h100, 32'hA2, 16'hFFFF, 15'h0180);
        push_pkt(32'h100, 16'h80, 8'h18);
        push_clr(3'd2, 1'b1, 32'h180, 1'b1, 1'b1, 1'b0);
        send_cmd(3'd2, 1'b0, 1'b0);
        wait_idle("t2");

        // Retransmit from acked_seq, no rewind write.
        set_state(32'h300, 32'h200, 32'hA3, 16'h1000, 15'h0300);
        push_pkt(32'h200, 16'h100, 8'h18);
        push_clr(3'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        send_cmd(3'd3, 1'b0, 1'b1);
        wait_idle("t3");

        // Pure ACK, nothing to send.
        set_state(32'h400, 32'h400, 32'hA4, 16'hFFFF, 15'h0400);
        push_pkt(32'h400, 16'h0, 8'h10);
        push_clr(3'd4, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        send_cmd(3'd4, 1'b1, 1'b0);
        wait_idle("t4");

        // Seq wraps 2^32 and tail pointer wrap bit differs.
        set_state(32'hFFFF_FF00, 32'hFFFF_FF00, 32'hA5, 16'hFFFF, 15'h0100);
        push_pkt(32'hFFFF_FF00, 16'h200, 8'h18);
        push_clr(3'd5, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        send_cmd(3'd5, 1'b0, 1'b0);
        wait_idle("t5");

        // Peer window exhausted with data pending.
        set_state(32'h800, 32'h400, 32'hA6, 16'h0400, 15'h0850);
`ifdef TCP_TX_ZERO_WIN_PROBE_EN
        push_pkt(32'h800, 16'h1, 8'h18);
`endif
        push_clr(3'd6, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        send_cmd(3'd6, 1'b0, 1'b0);
        wait_idle("t6");

        // Back-pressure: descriptor held stable while pkt_rdy low.
        pkt_rdy = 1'b0;
        set_state(32'h1000, 32'h1000, 32'hA7, 16'hFFFF, 15'h1100);
        push_pkt(32'h1000, 16'h100, 8'h18);
        push_clr(3'd7, 1'b1, 32'h1100, 1'b1, 1'b1, 1'b0);
        send_cmd(3'd7, 1'b0, 1'b0);
        wait_pkt("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {pkt_val, sched_clr_val, pkt_seq, pkt_payload_len, pkt_flags[5:0]},
                {1'b1, 1'b0, 32'h1000, 16'h100, 6'h18});
        end
        pkt_rdy = 1'b1;
        wait_idle("t7");

        // Reset while stalled in SEND: command dropped, no write-back or clear.
        pkt_rdy = 1'b0;
        set_state(32'h2000, 32'h2000, 32'hA8, 16'hFFFF, 15'h2100);
        send_cmd(3'd0, 1'b1, 1'b0);
        wait_pkt("rst_send");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {61'd0, sched_cmd_rdy, pkt_val, sched_clr_val}, 64'd4);
        @(negedge clk);
        rst = 1'b0;
        pkt_rdy = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_quiet", {62'd0, seq_wr_val, sched_clr_val}, 64'd0);

        chk("pkt_q_empty", 64'(pkt_q.size()), 64'd0);
        chk("clr_q_empty", 64'(clr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
